freq_meter: RTL

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 13 +
 rtl/freq_meter_sync_rise.sv | 37 +++
 rtl/freq_meter.sv | 100 ++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: measurement FSM states and the
// default counter width / timeout used when the top is instantiated bare.
package freq_meter_pkg;

  localparam int unsigned DEFAULT_N       = 24;
  localparam int unsigned DEFAULT_TIMEOUT = (32'd1 << DEFAULT_N) - 32'd1;

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } state_t;

endpackage

// File: rtl/freq_meter_sync_rise.sv
// sync_rise: brings the asynchronous sig_in into the clk domain through a
// two-flop synchronizer, keeps one extra delayed copy, and flags a rising edge.
//   clk    : clock
//   reset  : asynchronous, active-high; clears all three flops
//   sig_in : asynchronous input
//   level  : synchronized level of sig_in
//   rise   : high for one cycle when the synchronized level goes 0 -> 1
module sync_rise (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic level,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= sig_in;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  // Delay flop resets to 0, so a level already high at reset release still
  // produces one rise once it has crossed the synchronizer.
  assign level = sync_q;
  assign rise  = sync_q & ~dly_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: measures period and high time of sig_in in clk cycles, between
// consecutive rising edges, with a timeout when no edge arrives.
//   clk       : clock, all logic on posedge
//   reset     : asynchronous, active-high
//   sig_in    : measured square wave, asynchronous to clk
//   period    : clk cycles between the last two rising edges
//   high_time : clk cycles sig_in (synchronized) was high in that period
//   valid     : one-cycle pulse, period/high_time updated
//   timeout   : one-cycle pulse, no rising edge within TIMEOUT cycles
//   busy      : high while a measurement is in progress
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned N       = DEFAULT_N,
  parameter int unsigned TIMEOUT = (32'd1 << N) - 32'd1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sig_in,
  output logic [N-1:0] period,
  output logic [N-1:0] high_time,
  output logic         valid,
  output logic         timeout,
  output logic         busy
);

  localparam logic [N-1:0] TMO = N'(TIMEOUT);
  localparam logic [N-1:0] ONE = N'(1);

  logic         level;
  logic         rise;
  state_t       state;
  logic [N-1:0] cnt;
  logic [N-1:0] hi_cnt;

  sync_rise u_sync_rise (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .level  (level),
    .rise   (rise)
  );

  // cnt saturates at TMO by leaving MEASURE, so it never wraps; hi_cnt only
  // advances alongside cnt, so hi_cnt <= cnt holds throughout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WAIT_EDGE;
      cnt       <= '0;
      hi_cnt    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        WAIT_EDGE: begin
          if (rise) begin
            state  <= MEASURE;
            cnt    <= ONE;
            hi_cnt <= ONE;
          end else begin
            cnt    <= '0;
            hi_cnt <= '0;
          end
        end
        MEASURE: begin
          // A rise coinciding with cnt == TMO is reported, not timed out.
          if (rise) begin
            period    <= cnt;
            high_time <= hi_cnt;
            valid     <= 1'b1;
            cnt       <= ONE;
            hi_cnt    <= ONE;
          end else if (cnt == TMO) begin
            timeout <= 1'b1;
            state   <= WAIT_EDGE;
            cnt     <= '0;
            hi_cnt  <= '0;
          end else begin
            cnt <= cnt + ONE;
            if (level) begin
              hi_cnt <= hi_cnt + ONE;
            end
          end
        end
        default: begin
          state  <= WAIT_EDGE;
          cnt    <= '0;
          hi_cnt <= '0;
        end
      endcase
    end
  end

  assign busy = (state == MEASURE);

endmodule
